sha256_sched: RTL and testbench
===============================

Name: sha256_sched

Overview:
- Round sequencer and message-schedule generator for the SHA-256 compression datapath.
- Accepts each 512-bit block as 16 big-endian 32-bit words over a valid/ready stream.
- Issues one round per cycle, 64 rounds in total: round index, W_t, and first-block / state-update controls to the compression core.
- Sits between the message/padding front end and the compression core; it owns the W expansion so the core holds only working variables and the hash state.

Parameters:
- NUM_ROUNDS, 64, rounds per block; fixed at 64, and elaboration fails for any other value.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  message word valid
- in_ready  out  1  sched can accept a word
- in_data  in  32  message word; word 0 of the block first
- in_last  in  1  block is the final block of the message; sampled only with word 15
- round_en  out  1  core performs one round this cycle
- round_idx  out  6  round number t, 0..63; selects K_t in the core
- w_t  out  32  schedule word for round t
- first_blk  out  1  with round 0 only: core loads IV instead of the current state
- hash_update  out  1  one-cycle pulse: core adds working vars into the state
- done  out  1  one-cycle pulse, coincident with hash_update of the last block
- busy  out  1  high while a block is in flight (LOAD after word 0, EXPAND, FINAL)

Behaviour:
- All outputs are registered.
- Reset values: in_ready=0 during reset and 1 in the first cycle after release; round_en, first_blk, hash_update, done, busy = 0; round_idx, w_t = 0.
- Internal first-message flag is set by reset.
- States:
  - IDLE: in_ready=1. A handshake (in_valid & in_ready) on word 0 moves to LOAD.
  - LOAD (word count t=1..15): in_ready=1. Each handshake stores the word into a 16-entry shift window and increments t. The handshake on word 15 moves to EXPAND.
  - EXPAND: runs 48 cycles, t=16..63, with in_ready=0. Each cycle computes W_t = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16] mod 2^32 and shifts it into the window.
    - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
    - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - FINAL: one cycle, then IDLE.
- Round issue:
  - Handshake on word k at cycle n produces round_en=1, round_idx=k, w_t=in_data at cycle n+1.
  - With no handshake in IDLE/LOAD, round_en=0 the next cycle; this is a bubble, and the core must hold.
- Timing from word 15 accepted at cycle c:
  - Rounds 16..63 appear at c+2..c+49 with round_en continuously high.
  - hash_update=1 at c+50.
  - in_ready is 0 from c+1 to c+49 and is 1 again at c+50, so the next block's word 0 may be accepted in the same cycle as hash_update.
- first_blk=1 together with round 0 when the first-message flag is set. The flag clears on word 0 acceptance and is set again by the FINAL of a block whose latched in_last=1.
- done=1 together with hash_update when the latched in_last=1.
- in_last on words 0..14 is ignored.
- in_data and in_last are don't-care when in_valid=0.
- in_valid deasserted mid-block leaves the partial block in LOAD indefinitely; there is no timeout.
- Reset mid-block discards the partial block; the next word accepted is word 0 of a first block.

Optional Feature:
- Macro SHA256_BLKCNT_EN.
- Defined: adds output blk_cnt[31:0].
  - Reset 0; increments by 1 in the cycle hash_update is asserted; wraps 0xFFFFFFFF -> 0.
  - Also adds input blk_cnt_clr (synchronous clear, priority over increment).
- Undefined: neither port exists and there is no counter logic.

Test Plan:
- "abc" padded block (0x61626380, 13 zero words, 0x00000000, 0x00000018), in_last=1, in_valid held high:
  - round_idx 0..63 consecutive.
  - W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB.
  - hash_update and done together at c+50; first_blk only with round 0.
- Two-block message (NIST 448-bit vector, 2 blocks):
  - first_blk with block 1 round 0 only.
  - done only on block 2.
  - Block 2 word 0 accepted in the hash_update cycle of block 1 with no lost cycle.
- Random in_valid gaps during LOAD:
  - round_en low exactly in bubble cycles.
  - round_idx and w_t match accepted words in order.
  - EXPAND is unaffected.
- in_valid=1 throughout EXPAND/FINAL: in_ready=0 for exactly 49 cycles; no word consumed.
- rst asserted after word 9:
  - All outputs return to reset values asynchronously.
  - The next block is treated as first (first_blk=1).
  - The stale words do not appear in its W values.
- SHA256_BLKCNT_EN defined:
  - 3 blocks give blk_cnt=3.
  - blk_cnt_clr coincident with hash_update gives 0.
  - Preloaded 0xFFFFFFFF wraps to 0.

Source files
------------

// File: rtl/sha256_sched.sv
// sha256_sched -- SHA-256 round sequencer and message-schedule generator.
//
// Accepts a 512-bit block as 16 big-endian 32-bit words over a valid/ready
// stream and issues one compression round per cycle (64 rounds per block).
// Rounds 0..15 forward the accepted words. Rounds 16..63 are expanded
// internally from a 16-word sliding window.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   in_valid/in_ready/in_data/in_last
//                 message word stream; in_last is sampled with word 15 only
//   round_en      core performs a round this cycle (low = bubble, core holds)
//   round_idx     round number t (selects K_t in the core)
//   w_t           schedule word W_t
//   first_blk     with round 0: core loads IV instead of current state
//   hash_update   one-cycle pulse: core folds working vars into the state
//   done          with hash_update of the final block of a message
//   busy          a block is in flight
//
// Optional feature (macro SHA256_BLKCNT_EN):
//   blk_cnt_clr   synchronous clear of blk_cnt (wins over increment)
//   blk_cnt       count of completed blocks, wraps at 2^32
//
// All outputs are registered.

module sha256_sched #(
  parameter int unsigned NUM_ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        round_en,
  output logic [5:0]  round_idx,
  output logic [31:0] w_t,
  output logic        first_blk,
  output logic        hash_update,
  output logic        done,
  output logic        busy
`ifdef SHA256_BLKCNT_EN
  ,
  input  logic        blk_cnt_clr,
  output logic [31:0] blk_cnt
`endif
);

  if (NUM_ROUNDS != 64) begin : g_bad_rounds
    $error("sha256_sched: NUM_ROUNDS must be 64");
  end

  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EXPAND,
    S_FINAL
  } state_e;

  state_e             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  // Element i holds W[t-16+i] when computing W_t; element 15 is the newest.
  logic [15:0][31:0]  win_q, win_d;
  logic               last_q, last_d;
  logic               first_msg_q, first_msg_d;

  logic               in_ready_q, in_ready_d;
  logic               round_en_q, round_en_d;
  logic [5:0]         round_idx_q, round_idx_d;
  logic [31:0]        w_t_q, w_t_d;
  logic               first_blk_q, first_blk_d;
  logic               hash_update_q, hash_update_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               accept;
  logic [31:0]        w_new;

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign accept = in_valid & in_ready_q;
  assign w_new  = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    win_d         = win_q;
    last_d        = last_q;
    first_msg_d   = first_msg_q;
    round_en_d    = 1'b0;
    round_idx_d   = round_idx_q;
    w_t_d         = w_t_q;
    first_blk_d   = 1'b0;
    hash_update_d = 1'b0;
    done_d        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          win_d       = {in_data, win_q[15:1]};
          round_en_d  = 1'b1;
          round_idx_d = 6'd0;
          w_t_d       = in_data;
          first_blk_d = first_msg_q;
          first_msg_d = 1'b0;
          cnt_d       = 6'd1;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          win_d       = {in_data, win_q[15:1]};
          round_en_d  = 1'b1;
          round_idx_d = cnt_q;
          w_t_d       = in_data;
          cnt_d       = cnt_q + 6'd1;
          if (cnt_q == 6'd15) begin
            last_d  = in_last;
            state_d = S_EXPAND;
          end
        end
      end
      S_EXPAND: begin
        win_d       = {w_new, win_q[15:1]};
        round_en_d  = 1'b1;
        round_idx_d = cnt_q;
        w_t_d       = w_new;
        cnt_d       = cnt_q + 6'd1;
        if (cnt_q == LAST_ROUND) begin
          cnt_d   = 6'd0;
          state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        hash_update_d = 1'b1;
        done_d        = last_q;
        if (last_q) begin
          first_msg_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Registered ready/busy follow the state being entered, so ready
    // returns in the same cycle that hash_update is presented.
    in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      win_q         <= '0;
      last_q        <= 1'b0;
      first_msg_q   <= 1'b1;
      in_ready_q    <= 1'b0;
      round_en_q    <= 1'b0;
      round_idx_q   <= '0;
      w_t_q         <= '0;
      first_blk_q   <= 1'b0;
      hash_update_q <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      win_q         <= win_d;
      last_q        <= last_d;
      first_msg_q   <= first_msg_d;
      in_ready_q    <= in_ready_d;
      round_en_q    <= round_en_d;
      round_idx_q   <= round_idx_d;
      w_t_q         <= w_t_d;
      first_blk_q   <= first_blk_d;
      hash_update_q <= hash_update_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign round_en    = round_en_q;
  assign round_idx   = round_idx_q;
  assign w_t         = w_t_q;
  assign first_blk   = first_blk_q;
  assign hash_update = hash_update_q;
  assign done        = done_q;
  assign busy        = busy_q;

`ifdef SHA256_BLKCNT_EN
  logic [31:0] blk_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt_q <= '0;
    end else if (blk_cnt_clr) begin
      blk_cnt_q <= '0;
    end else if (hash_update_q) begin
      blk_cnt_q <= blk_cnt_q + 32'd1;
    end
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_sha256_sched.sv
// Directed bench for sha256_sched: "abc" block, two-block NIST message,
// LOAD bubbles, back-to-back blocks, and mid-block reset. Block counter
// checks are compiled in when SHA256_BLKCNT_EN is defined.

module tb_sha256_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        round_en;
  logic [5:0]  round_idx;
  logic [31:0] w_t;
  logic        first_blk;
  logic        hash_update;
  logic        done;
  logic        busy;
`ifdef SHA256_BLKCNT_EN
  logic        blk_cnt_clr = 1'b0;
  logic [31:0] blk_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] msg [5][16];
  logic [31:0] exp_w [64];
  logic [31:0] cap16, cap17, cap63;

  sha256_sched #(.NUM_ROUNDS(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .round_en    (round_en),
    .round_idx   (round_idx),
    .w_t         (w_t),
    .first_blk   (first_blk),
    .hash_update (hash_update),
    .done        (done),
    .busy        (busy)
`ifdef SHA256_BLKCNT_EN
    ,
    .blk_cnt_clr (blk_cnt_clr),
    .blk_cnt     (blk_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_exp(input int b);
    for (int t = 0; t < 64; t++) begin
      if (t < 16) exp_w[t] = msg[b][t];
      else exp_w[t] = s1(exp_w[t-2]) + exp_w[t-7] + s0(exp_w[t-15]) + exp_w[t-16];
    end
  endtask

  // Sends block b and follows it through EXPAND/FINAL, ending in the
  // hash_update cycle. With hold_next, word 0 of block b+1 is presented
  // throughout EXPAND/FINAL.
  task automatic send_block(input int b, input bit last, input bit exp_first,
                            input bit gaps, input bit hold_next);
    int lows;
    int waitn;
    int ng;
    build_exp(b);
    for (int k = 0; k < 16; k++) begin
      ng = 0;
      if (gaps) ng = (k == 1) ? 2 : int'($urandom_range(0, 2));
      for (int g = 0; g < ng; g++) begin
        in_valid = 1'b0;
        in_data  = 32'hBADBAD00;
        tick();
        chk("bubble_round_en", 32'(round_en), 0);
      end
      in_valid = 1'b1;
      in_data  = msg[b][k];
      in_last  = (k == 15) ? last : ~last;
      waitn = 0;
      while (!in_ready && waitn < 100) begin
        tick();
        waitn++;
      end
      chk("in_ready_word", 32'(in_ready), 1);
      tick();
      chk("round_en_load", 32'(round_en), 1);
      chk("round_idx_load", 32'(round_idx), k);
      chk("w_t_load", w_t, exp_w[k]);
      chk("first_blk_load", 32'(first_blk), 32'(k == 0 && exp_first));
      chk("busy_load", 32'(busy), 1);
    end
    in_valid = hold_next;
    in_data  = hold_next ? msg[b+1][0] : 32'h0;
    in_last  = 1'b0;
    lows = in_ready ? 0 : 1;
    for (int t = 16; t < 64; t++) begin
      tick();
      chk("round_en_exp", 32'(round_en), 1);
      chk("round_idx_exp", 32'(round_idx), t);
      chk("w_t_exp", w_t, exp_w[t]);
      chk("first_blk_exp", 32'(first_blk), 0);
      chk("hash_update_exp", 32'(hash_update), 0);
      if (!in_ready) lows++;
      if (t == 16) cap16 = w_t;
      if (t == 17) cap17 = w_t;
      if (t == 63) cap63 = w_t;
    end
    tick();
    chk("in_ready_low_cycles", lows, 49);
    chk("hash_update", 32'(hash_update), 1);
    chk("done", 32'(done), 32'(last));
    chk("in_ready_final", 32'(in_ready), 1);
    chk("round_en_final", 32'(round_en), 0);
    chk("busy_final", 32'(busy), 0);
  endtask

  initial begin
    logic [31:0] nist1 [16];
    nist1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
              32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
              32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
              32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    for (int k = 0; k < 16; k++) begin
      msg[0][k] = 32'h0;
      msg[1][k] = nist1[k];
      msg[2][k] = 32'h0;
      msg[3][k] = (32'(k) * 32'h01010101) ^ 32'hA5A5A5A5;
      msg[4][k] = 32'hBAD00000 + 32'(k);
    end
    msg[0][0]  = 32'h61626380;
    msg[0][15] = 32'h00000018;
    msg[2][15] = 32'h000001C0;

    // Reset values
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_round_en", 32'(round_en), 0);
    chk("rst_round_idx", 32'(round_idx), 0);
    chk("rst_w_t", w_t, 0);
    chk("rst_first_blk", 32'(first_blk), 0);
    chk("rst_hash_update", 32'(hash_update), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    tick();
    chk("in_ready_after_rst", 32'(in_ready), 1);

    // "abc"
    send_block(0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("abc_W16", cap16, 32'h61626380);
    chk("abc_W17", cap17, 32'h000F0000);
    chk("abc_W63", cap63, 32'h12B1EDEB);

    // Two-block NIST message, block 2 word 0 held during block 1 expansion
    send_block(1, 1'b0, 1'b1, 1'b0, 1'b1);
    send_block(2, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("nist2_W16", cap16, 32'h00000000);
    chk("nist2_W17", cap17, 32'h00D80000);
`ifdef SHA256_BLKCNT_EN
    tick();
    chk("blk_cnt_3", blk_cnt, 3);
`endif

    // Bubbles during LOAD
    send_block(3, 1'b1, 1'b1, 1'b1, 1'b0);
`ifdef SHA256_BLKCNT_EN
    blk_cnt_clr = 1'b1;
    tick();
    blk_cnt_clr = 1'b0;
    chk("blk_cnt_clr", blk_cnt, 0);
`endif

    // Reset after word 9 of a stale block
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = msg[4][k];
      in_last  = 1'b1;
      tick();
      chk("stale_round_idx", 32'(round_idx), k);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_in_ready", 32'(in_ready), 0);
    chk("arst_round_en", 32'(round_en), 0);
    chk("arst_round_idx", 32'(round_idx), 0);
    chk("arst_w_t", w_t, 0);
    chk("arst_busy", 32'(busy), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("in_ready_after_arst", 32'(in_ready), 1);
`ifdef SHA256_BLKCNT_EN
    force dut.blk_cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.blk_cnt_q;
`endif
    send_block(0, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef SHA256_BLKCNT_EN
    tick();
    chk("blk_cnt_wrap", blk_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
